candle_sequencer: RTL and testbench

- Command scheduler for the candle extinguish/light datapath. Collects per-candle light and extinguish requests from multiple sources and arbitrates them round-robin.
- Serialises granted requests into single position/enable commands for the position-matched extinguisher stage. Holds each command long enough for one full scan of that stage's position counter.
- Tracks the lit/unlit state of every candle.

---
 rtl/candle_sequencer.sv | 179 +++++++++++++++++
 tb/tb_candle_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/candle_sequencer.sv
// Round-robin light/extinguish command scheduler for the candle datapath.
// Define SEQ_STATS_EN to build the saturating completed-command counter on op_count.
module candle_sequencer #(
  parameter int unsigned          N_CANDLES   = 8,
  parameter int unsigned          HOLD_CYCLES = 16,
  parameter int unsigned          GAP_CYCLES  = 4,
  parameter logic [N_CANDLES-1:0] LIT_INIT    = {N_CANDLES{1'b1}}
) (
  input  logic                         sys_clk,
  input  logic                         clr_n,
  input  logic [N_CANDLES-1:0]         req_ext,
  input  logic [N_CANDLES-1:0]         req_light,
  output logic [$clog2(N_CANDLES)-1:0] cmd_position,
  output logic                         cmd_enable,
  output logic                         cmd_light,
  output logic [N_CANDLES-1:0]         lit_state,
  output logic                         busy,
  output logic [7:0]                   op_count
);

  localparam int unsigned POS_W   = $clog2(N_CANDLES);
  localparam int unsigned MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [POS_W-1:0] LAST_IDX  = POS_W'(N_CANDLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 light_q, light_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic [POS_W-1:0]     last_q, last_d;
  logic [N_CANDLES-1:0] lit_q, lit_d;
  logic [N_CANDLES-1:0] pend_ext_q, pend_ext_d;
  logic [N_CANDLES-1:0] pend_light_q, pend_light_d;
  logic [N_CANDLES-1:0] pend_any;
  logic                 found;
  logic [POS_W-1:0]     grant_idx;
  logic [POS_W-1:0]     cand;
  logic                 hold_done;

  assign pend_any  = pend_ext_q | pend_light_q;
  assign hold_done = (state_q == ST_HOLD) && (cnt_q == '0);

  // Request capture, round-robin grant search and FSM next-state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pos_d        = pos_q;
    light_d      = light_q;
    last_d       = last_q;
    lit_d        = lit_q;
    pend_ext_d   = pend_ext_q;
    pend_light_d = pend_light_q;
    found        = 1'b0;
    grant_idx    = '0;
    cand         = '0;

    // Extinguish beats light; the candle in service ignores new requests.
    for (int unsigned i = 0; i < N_CANDLES; i++) begin
      if (!((state_q != ST_IDLE) && (pos_q == POS_W'(i)))) begin
        if (req_ext[i]) begin
          if (lit_q[i]) begin
            pend_ext_d[i]   = 1'b1;
            pend_light_d[i] = 1'b0;
          end
        end else if (req_light[i] && !lit_q[i]) begin
          pend_light_d[i] = 1'b1;
          pend_ext_d[i]   = 1'b0;
        end
      end
    end

    for (int unsigned k = 1; k <= N_CANDLES; k++) begin
      cand = POS_W'((32'(last_q) + k) % N_CANDLES);
      if (!found && pend_any[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          pos_d                   = grant_idx;
          light_d                 = pend_light_q[grant_idx];
          pend_ext_d[grant_idx]   = 1'b0;
          pend_light_d[grant_idx] = 1'b0;
          last_d                  = grant_idx;
          cnt_d                   = HOLD_LOAD;
          state_d                 = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          lit_d[pos_q] = light_q;
          cnt_d        = GAP_LOAD;
          state_d      = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    en_d   = (state_d == ST_HOLD);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pos_q        <= '0;
      light_q      <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      last_q       <= LAST_IDX;
      lit_q        <= LIT_INIT;
      pend_ext_q   <= '0;
      pend_light_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      light_q      <= light_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      last_q       <= last_d;
      lit_q        <= lit_d;
      pend_ext_q   <= pend_ext_d;
      pend_light_q <= pend_light_d;
    end
  end

  assign cmd_position = pos_q;
  assign cmd_enable   = en_q;
  assign cmd_light    = light_q;
  assign lit_state    = lit_q;
  assign busy         = busy_q;

`ifdef SEQ_STATS_EN
  logic [7:0] op_count_q, op_count_d;

  // Saturating count of completed commands.
  always_comb begin
    op_count_d = op_count_q;
    if (hold_done && (op_count_q != 8'hFF)) begin
      op_count_d = op_count_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      op_count_q <= 8'h00;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`else
  logic unused_hold_done;
  assign unused_hold_done = hold_done;
  assign op_count         = 8'h00;
`endif

endmodule

// File: tb/tb_candle_sequencer.sv
// Directed scoreboard bench for candle_sequencer: expected commands are queued at
// stimulus time and checked as cmd_enable rises; lit_state tracked by a local model.
module tb_candle_sequencer;

  localparam int unsigned HOLD = 16;
  localparam int unsigned GAP  = 4;

  typedef struct packed {
    logic [2:0] pos;
    logic       light;
  } cmd_t;

  logic       sys_clk;
  logic       clr_n;
  logic [7:0] req_ext;
  logic [7:0] req_light;
  logic [2:0] cmd_position;
  logic       cmd_enable;
  logic       cmd_light;
  logic [7:0] lit_state;
  logic       busy;
  logic [7:0] op_count;

  candle_sequencer dut (
    .sys_clk      (sys_clk),
    .clr_n        (clr_n),
    .req_ext      (req_ext),
    .req_light    (req_light),
    .cmd_position (cmd_position),
    .cmd_enable   (cmd_enable),
    .cmd_light    (cmd_light),
    .lit_state    (lit_state),
    .busy         (busy),
    .op_count     (op_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hold_cnt = 0;
  int   fall_cyc = 0;
  int   rise_cyc = 0;
  int   done_cnt = 0;
  bit   en_prev = 1'b0;
  bit   busy_prev = 1'b0;
  bit   sb_on = 1'b1;
  bit   b2b = 1'b0;
  bit   have_rise = 1'b0;
  cmd_t cur;
  cmd_t exp_q[$];
  logic [7:0] lit_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge, then check commands against the scoreboard.
  task automatic tick();
    int exp_ops;
    @(negedge sys_clk);
    cyc++;
    if (cmd_enable && !en_prev) begin
      if (b2b && have_rise) chk("cmd_spacing", 32'(cyc - rise_cyc), 32'(HOLD + GAP + 1));
      rise_cyc  = cyc;
      have_rise = 1'b1;
      hold_cnt  = 0;
      if (sb_on) begin
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("cmd_position", 32'(cmd_position), 32'(cur.pos));
          chk("cmd_light", 32'(cmd_light), 32'(cur.light));
        end
      end
    end
    if (cmd_enable) begin
      hold_cnt++;
      if (sb_on && hold_cnt > 1) chk("pos_stable", 32'({cmd_position, cmd_light}), 32'({cur.pos, cur.light}));
    end
    if (!cmd_enable && en_prev) begin
      chk("hold_len", 32'(hold_cnt), 32'(HOLD));
      fall_cyc = cyc;
      done_cnt++;
      if (sb_on) lit_m[cur.pos] = cur.light;
`ifdef SEQ_STATS_EN
      exp_ops = (done_cnt < 255) ? done_cnt : 255;
`else
      exp_ops = 0;
`endif
      chk("op_count", 32'(op_count), 32'(exp_ops));
    end
    if (!busy && busy_prev) chk("gap_len", 32'(cyc - fall_cyc), 32'(GAP));
    en_prev   = cmd_enable;
    busy_prev = busy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    clr_n = 1'b0;
    #1;
    en_prev   = 1'b0;
    busy_prev = 1'b0;
    lit_m     = 8'hFF;
    done_cnt  = 0;
    have_rise = 1'b0;
    tick();
    clr_n = 1'b1;
  endtask

  initial begin
    bit started;
    clr_n     = 1'b0;
    req_ext   = 8'h00;
    req_light = 8'h00;
    lit_m     = 8'hFF;
    cur       = '0;
    run(2);
    chk("rst_enable", 32'(cmd_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_position", 32'(cmd_position), 32'd0);
    chk("rst_light", 32'(cmd_light), 32'd0);
    chk("rst_lit", 32'(lit_state), 32'hFF);
    chk("rst_op_count", 32'(op_count), 32'd0);
    clr_n = 1'b1;
    tick();

    // Single extinguish pulse on candle 2: enable one cycle after capture.
    req_ext = 8'h04;
    exp_q.push_back('{pos: 3'd2, light: 1'b0});
    tick();
    req_ext = 8'h00;
    chk("lat_not_yet", 32'(cmd_enable), 32'd0);
    tick();
    chk("lat_enable", 32'(cmd_enable), 32'd1);
    run(28);
    chk("t1_lit", 32'(lit_state), 32'(lit_m));
    chk("t1_lit_abs", 32'(lit_state), 32'hFB);
    chk("t1_idle", 32'(busy), 32'd0);

    // Two simultaneous requests after reset: candle 0 first, then 7.
    pulse_reset();
    b2b = 1'b1;
    req_ext = 8'h81;
    exp_q.push_back('{pos: 3'd0, light: 1'b0});
    exp_q.push_back('{pos: 3'd7, light: 1'b0});
    tick();
    req_ext = 8'h00;
    run(50);
    b2b = 1'b0;
    chk("t2_lit", 32'(lit_state), 32'h7E);
    chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);

    // No-op requests: extinguish unlit 0 with light 0 together, light an already-lit 1.
    req_ext   = 8'h01;
    req_light = 8'h01;
    tick();
    req_ext   = 8'h00;
    req_light = 8'h02;
    tick();
    req_light = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_busy", 32'(busy), 32'd0);
    end
    chk("t3_lit", 32'(lit_state), 32'h7E);
    req_light = 8'h01;
    exp_q.push_back('{pos: 3'd0, light: 1'b1});
    tick();
    req_light = 8'h00;
    run(30);
    chk("t3_relit", 32'(lit_state), 32'(lit_m));

    // Requests during HOLD on candle 3: candle 3 ignored, candle 5 queued behind.
    req_ext = 8'h08;
    exp_q.push_back('{pos: 3'd3, light: 1'b0});
    tick();
    req_ext = 8'h00;
    started = 1'b0;
    for (int i = 0; i < 5 && !started; i++) begin
      tick();
      started = cmd_enable;
    end
    chk("t4_started", 32'(started), 32'd1);
    run(3);
    req_ext   = 8'h28;
    req_light = 8'h08;
    exp_q.push_back('{pos: 3'd5, light: 1'b0});
    tick();
    req_ext   = 8'h00;
    req_light = 8'h00;
    run(45);
    chk("t4_lit", 32'(lit_state), 32'(lit_m));
    chk("t4_lit_abs", 32'(lit_state), 32'h57);
    req_ext = 8'h50;
    exp_q.push_back('{pos: 3'd6, light: 1'b0});
    exp_q.push_back('{pos: 3'd4, light: 1'b0});
    tick();
    req_ext = 8'h00;
    run(50);
    chk("t4_rr_lit", 32'(lit_state), 32'(lit_m));
    chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of HOLD drops the command immediately.
    req_light = 8'h08;
    exp_q.push_back('{pos: 3'd3, light: 1'b1});
    tick();
    req_light = 8'h00;
    run(6);
    chk("t5_in_hold", 32'(cmd_enable), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("t5_rst_enable", 32'(cmd_enable), 32'd0);
    chk("t5_rst_lit", 32'(lit_state), 32'hFF);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ops", 32'(op_count), 32'd0);
    en_prev   = 1'b0;
    busy_prev = 1'b0;
    lit_m     = 8'hFF;
    done_cnt  = 0;
    have_rise = 1'b0;
    tick();
    clr_n = 1'b1;
    run(40);
    chk("t5_no_resume", 32'(busy), 32'd0);
    chk("t5_lit_after", 32'(lit_state), 32'hFF);

    // Back-to-back toggling on every candle until 300 commands complete.
    sb_on = 1'b0;
    b2b   = 1'b1;
    for (int i = 0; i < 7000 && done_cnt < 300; i++) begin
      req_ext   = lit_state;
      req_light = ~lit_state;
      tick();
    end
    req_ext   = 8'h00;
    req_light = 8'h00;
    b2b       = 1'b0;
    chk("stress_done", 32'(done_cnt >= 300), 32'd1);
    run(200);
    chk("stress_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
